divider_iterative: RTL and testbench
====================================

Name: divider_iterative

Overview:
- Iterative radix-2 restoring divider; the inverse unit to the iterative multiplier in the functional-units set.
- Takes a WIDTH-bit dividend and divisor, signed or unsigned, and returns quotient and remainder after a fixed latency.
- Sits beside the multiplier behind the ALU and serves DIV/DIVU-class instructions.
- Handshake style matches the multiplier: a one-cycle valid_in pulse starts an operation, and a one-cycle valid_out pulse marks the result.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- valid_in  in  1  start pulse; samples a, b, is_signed
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- busy  out  1  operation in progress; valid_in ignored while high
- valid_out  out  1  one-cycle pulse, q/r/div_by_zero valid
- q  out  WIDTH  quotient
- r  out  WIDTH  remainder
- div_by_zero  out  1  b was 0 for the completed operation

Behaviour:
- Interface: one clock (clk); reset is synchronous, active low (rst_n).
- Reset: state IDLE, busy=0, valid_out=0, q=0, r=0, div_by_zero=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation; no valid_out is produced.
- States:
  - IDLE: on valid_in=1, latch the operands and go to RUN.
  - RUN: performs exactly WIDTH iterations, then goes to FIX.
  - FIX: one cycle, then returns to IDLE.
- Accept (edge E0, state IDLE, valid_in=1):
  - Latch is_signed, sign_a = is_signed & a[MSB], sign_b = is_signed & b[MSB].
  - Latch |a| and |b| as magnitudes. Negating the most negative value yields its unsigned magnitude; no overflow handling is needed here.
  - Latch zflag = (b == 0).
  - Clear the partial remainder (WIDTH+1 bits). Counter = 0.
- RUN (edges E1..E_WIDTH), one step per edge:
  - rem' = {rem[WIDTH-1:0], dvd[MSB]}; dvd shifts left by 1.
  - If rem' >= |b|: rem = rem' - |b| and shift in quotient bit 1; else rem = rem' and shift in 0.
  - Counter increments; leave RUN when counter reaches WIDTH.
- FIX (edge E_WIDTH+1):
  - Normal case: q = (sign_a ^ sign_b) ? -quot : quot; r = sign_a ? -rem : rem.
  - zflag overrides: q = all ones, r = a as latched (original signed value), div_by_zero=1.
  - valid_out=1 in the following cycle only.
- Latency: valid_out is high in the cycle after edge E_{WIDTH+1}, i.e. 34 cycles after the accept edge for WIDTH=32. Latency is fixed and data-independent, including divide by zero.
- busy is high from after E0 through the cycle before valid_out. busy=0 while valid_out=1.
- valid_in while busy=1 is ignored, with no effect on the in-flight operation.
- valid_in in the valid_out cycle is accepted (back-to-back). That result pulse still completes normally.
- q, r and div_by_zero hold their values until the next FIX or reset.
- Signed overflow (most negative / -1) needs no special case; it yields q = most negative, r = 0.
- Unsigned mode never negates.

Decomposition:
- Package divider_pkg:
  - state typedef enum {IDLE, RUN, FIX}
  - default WIDTH constant
  - counter width as $clog2(WIDTH)+1
- Sub-module divider_step: combinational single restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Unit-testable on its own.

Test Plan:
- Unsigned a=100, b=7 -> q=14, r=2, div_by_zero=0; valid_out exactly 34 cycles after the accept edge, high for 1 cycle; busy=1 throughout.
- Signed a=-7 (0xFFFFFFF9), b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed a=7, b=-2 -> q=0xFFFFFFFD, r=1.
- Divide by zero:
  - signed a=0xFFFFFFFB, b=0 -> q=0xFFFFFFFF, r=0xFFFFFFFB, div_by_zero=1, same 34-cycle latency.
  - unsigned a=5, b=0 -> q=0xFFFFFFFF, r=5.
- a=0x80000000, b=0xFFFFFFFF:
  - signed -> q=0x80000000, r=0.
  - unsigned -> q=0, r=0x80000000.
- valid_in pulsed at cycle 10 after accept with different operands -> ignored, first result unchanged. Second op (50/5) issued in the valid_out cycle -> accepted, q=10, r=0 after 34 more cycles.
- rst_n low for 1 cycle at cycle 15 of an op -> all outputs 0 the next cycle, no valid_out ever appears. A new op issued afterwards completes correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Imported by the divider top and its single-step datapath.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it fits.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // Shifted remainder is one bit wider so the compare never overflows.
    always_comb begin
        shifted  = {rem, dvd_msb};
        q_bit    = (shifted >= {1'b0, div});
        rem_next = q_bit ? WIDTH'(shifted - {1'b0, div})
                         : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_iterative.sv
// Iterative radix-2 restoring divider, signed or unsigned, fixed
// latency of WIDTH+2 cycles from accept to the valid_out pulse.
module divider_iterative
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             sgn_a;
    logic             sgn_b;
    logic             zflag;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        neg_a = is_signed & a[WIDTH-1];
        neg_b = is_signed & b[WIDTH-1];
        abs_a = neg_a ? -a : a;
        abs_b = neg_b ? -b : b;
    end

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .div      (dvs),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    // Control FSM plus datapath registers and registered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            valid_out   <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            sgn_a       <= 1'b0;
            sgn_b       <= 1'b0;
            zflag       <= 1'b0;
            a_raw       <= '0;
            dvd         <= '0;
            dvs         <= '0;
            quot        <= '0;
            rem         <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sgn_a <= neg_a;
                        sgn_b <= neg_b;
                        zflag <= (b == '0);
                        a_raw <= a;
                        dvd   <= abs_a;
                        dvs   <= abs_b;
                        quot  <= '0;
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem  <= rem_nx;
                    dvd  <= {dvd[WIDTH-2:0], 1'b0};
                    quot <= {quot[WIDTH-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zflag) begin
                        q <= '1;
                        r <= a_raw;
                    end else begin
                        q <= (sgn_a ^ sgn_b) ? -quot : quot;
                        r <= sgn_a ? -rem : rem;
                    end
                    div_by_zero <= zflag;
                    valid_out   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: a driver pushes expected
// results, a negedge monitor pops and compares on each valid_out.
module tb_divider_iterative;

    localparam int W   = 32;
    localparam int LAT = 34;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         valid_out;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   last_exp = 0;

    divider_iterative #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid_out   (valid_out),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV truncating division.
    function automatic exp_t model(input bit s, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int c);
        exp_t   e;
        longint sx;
        longint sy;
        e.cyc = c;
        e.dz  = (y == 0);
        if (y == 0) begin
            e.q = '1;
            e.r = x;
        end else if (s) begin
            sx  = longint'($signed(x));
            sy  = longint'($signed(y));
            e.q = W'(sx / sy);
            e.r = W'(sx % sy);
        end else begin
            sx  = longint'({32'b0, x});
            sy  = longint'({32'b0, y});
            e.q = W'(sx / sy);
            e.r = W'(sx % sy);
        end
        return e;
    endfunction

    // Monitor: count cycles, check busy window and every result pulse.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sb.size() > 0 && cyc > sb[0].cyc - LAT && cyc < sb[0].cyc)
            chk("busy_run", {31'b0, busy}, 1);
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("q", q, e.q);
                chk("r", r, e.r);
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
                chk("latency_cycle", cyc, e.cyc);
                chk("busy_at_valid", {31'b0, busy}, 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic issue(input bit s, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        valid_in  = 1'b1;
        is_signed = s;
        a         = x;
        b         = y;
        last_exp  = cyc + LAT;
        sb.push_back(model(s, x, y, last_exp));
        step();
        valid_in = 1'b0;
    endtask

    task automatic run(input bit s, input logic [W-1:0] x,
                       input logic [W-1:0] y);
        wait_until(last_exp);
        issue(s, x, y);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_valid_out"}, {31'b0, valid_out}, 0);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_r"}, r, 0);
        chk({tag, "_dz"}, {31'b0, div_by_zero}, 0);
    endtask

    initial begin
        int acc;
        int lim;
        logic [W-1:0] x;
        logic [W-1:0] y;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) step();
        chk_zero("reset");
        rst_n    = 1'b1;
        step();
        last_exp = cyc;

        // Basic op with an ignored mid-flight pulse, then back-to-back.
        issue(0, 100, 7);
        acc = last_exp - LAT;
        wait_until(acc + 10);
        valid_in  = 1'b1;
        is_signed = 1'b1;
        a         = 32'hDEAD_BEEF;
        b         = 3;
        step();
        valid_in = 1'b0;
        run(0, 50, 5);

        run(1, 32'hFFFF_FFF9, 2);
        run(1, 7, 32'hFFFF_FFFE);
        run(1, 32'hFFFF_FFFB, 0);
        run(0, 5, 0);
        run(1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Reset mid-operation aborts with no result.
        run(0, 1000, 3);
        acc = last_exp - LAT;
        wait_until(acc + 15);
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        chk_zero("abort");
        repeat (40) step();
        last_exp = cyc;
        run(1, 32'hFFFF_FF9C, 9);

        // Random ops, random gaps, occasional ignored pulses.
        for (int i = 0; i < 40; i++) begin
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 5))
                0: y = 0;
                1: y = W'($urandom_range(1, 15));
                2: y = -W'($urandom_range(1, 15));
                3: x = 32'h8000_0000;
                default: ;
            endcase
            wait_until(last_exp + $urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), x, y);
            if ($urandom_range(0, 2) == 0) begin
                wait_until(last_exp - LAT + $urandom_range(2, 30));
                valid_in = 1'b1;
                a        = $urandom();
                b        = $urandom();
                step();
                valid_in = 1'b0;
            end
        end

        lim = cyc + 200;
        while (sb.size() > 0 && cyc < lim) step();
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d results outstanding, expected 0",
                     sb.size());
        end
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
